// File: rtl/mem_nr1w_be.sv
// mem_nr1w_be: WORD x WIDTH memory with one byte-enabled write port and NREAD
// independent registered read ports.
//
// Ports:
//   clk         clock
//   rst         asynchronous active-high reset
//   busy        high while the post-reset clear sequence zeroes the array
//   waddr       write address (only the low ADDR_WIDTH bits are used)
//   wdata       write data
//   wbe         byte enables, bit k covers wdata[8k+7:8k]
//   we          write strobe
//   raddr       read addresses, port p at [32p+31:32p]
//   re          per-port read enable
//   rdata       read data, port p at [WIDTH*p+WIDTH-1:WIDTH*p]
//   rvalid      per-port read-data-valid
//   o_dbg_state current sequencer state (0 = CLEAR, 1 = READY)
//
// Handshake: there is no backpressure. A read on port p is accepted in any
// cycle where re[p]=1 and busy=0. For every accepted read, rvalid[p] is high
// for exactly one cycle, 1+OUT_REG clock edges later, with rdata[p] valid in
// that cycle. A write is accepted in any cycle where we=1 and busy=0. Reads and
// writes presented while busy=1 are dropped. rdata[p] holds its last value
// when no new data arrives.
module mem_nr1w_be #(
    parameter int WIDTH      = 32,
    parameter int WORD       = 1024,
    parameter int NREAD      = 2,
    parameter int READ_MODE  = 0,
    parameter int OUT_REG    = 0,
    parameter int INIT_CLEAR = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   busy,
    input  logic [31:0]            waddr,
    input  logic [WIDTH-1:0]       wdata,
    input  logic [WIDTH/8-1:0]     wbe,
    input  logic                   we,
    input  logic [NREAD*32-1:0]    raddr,
    input  logic [NREAD-1:0]       re,
    output logic [NREAD*WIDTH-1:0] rdata,
    output logic [NREAD-1:0]       rvalid,
    output logic                   o_dbg_state
);

    localparam int ADDR_WIDTH = $clog2(WORD);
    localparam int NBYTE      = WIDTH / 8;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [ADDR_WIDTH-1:0]   r_clr_cnt;
    logic [ADDR_WIDTH-1:0]   w_clr_cnt_next;
    logic                    w_busy;

    // Effective write port: the clear sequencer owns it while busy.
    logic                    w_wen;
    logic [ADDR_WIDTH-1:0]   w_waddr;
    logic [WIDTH-1:0]        w_wdata;
    logic [NBYTE-1:0]        w_wbe;
    logic [WIDTH-1:0]        w_wmask;

    (* ram_style = "block" *) logic [WIDTH-1:0] r_mem [WORD];

    // Upper address bits are intentionally ignored (addresses wrap).
    logic w_unused;
    assign w_unused = ^{waddr, raddr};

    // ---------------- clear sequencer ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_READY;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_clr_cnt <= w_clr_cnt_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_clr_cnt_next = r_clr_cnt;
        w_busy         = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_busy         = 1'b1;
                w_clr_cnt_next = r_clr_cnt + ADDR_WIDTH'(1);
                // The write of the last word happens on this edge.
                if (r_clr_cnt == ADDR_WIDTH'(WORD - 1)) begin
                    w_state_next = ST_READY;
                end
            end
            ST_READY: begin
                w_busy = 1'b0;
            end
        endcase
    end

    assign busy        = w_busy;
    assign o_dbg_state = r_state;

    // ---------------- write port ----------------
    assign w_wen   = w_busy | we;
    assign w_waddr = w_busy ? r_clr_cnt : waddr[ADDR_WIDTH-1:0];
    assign w_wdata = w_busy ? '0 : wdata;
    assign w_wbe   = w_busy ? '1 : wbe;

    always_comb begin
        w_wmask = '0;
        for (int k = 0; k < NBYTE; k++) begin
            w_wmask[8*k +: 8] = {8{w_wbe[k]}};
        end
    end

    always_ff @(posedge clk) begin
        if (w_wen) begin
            for (int k = 0; k < NBYTE; k++) begin
                if (w_wbe[k]) begin
                    r_mem[w_waddr][8*k +: 8] <= w_wdata[8*k +: 8];
                end
            end
        end
    end

    // ---------------- read ports ----------------
    for (genvar p = 0; p < NREAD; p++) begin : g_port
        logic [ADDR_WIDTH-1:0] w_raddr;
        logic [WIDTH-1:0]      w_old;
        logic [WIDTH-1:0]      w_rword;
        logic                  w_fwd;
        logic                  w_acc;
        logic [WIDTH-1:0]      r_rd1;
        logic                  r_v1;

        assign w_raddr = raddr[32*p +: ADDR_WIDTH];
        assign w_old   = r_mem[w_raddr];
        // Write-first: same-cycle write to the same word is merged into the
        // read result, byte by byte, under the write enables.
        assign w_fwd   = (READ_MODE != 0) && w_wen && (w_waddr == w_raddr);
        assign w_rword = w_fwd ? ((w_old & ~w_wmask) | (w_wdata & w_wmask)) : w_old;
        assign w_acc   = re[p] & ~w_busy;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_rd1 <= '0;
                r_v1  <= 1'b0;
            end else begin
                r_v1 <= w_acc;
                if (w_acc) begin
                    r_rd1 <= w_rword;
                end
            end
        end

        if (OUT_REG != 0) begin : g_out_reg
            logic [WIDTH-1:0] r_rd2;
            logic             r_v2;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_rd2 <= '0;
                    r_v2  <= 1'b0;
                end else begin
                    r_v2 <= r_v1;
                    if (r_v1) begin
                        r_rd2 <= r_rd1;
                    end
                end
            end

            assign rdata[WIDTH*p +: WIDTH] = r_rd2;
            assign rvalid[p]               = r_v2;
        end else begin : g_out_direct
            assign rdata[WIDTH*p +: WIDTH] = r_rd1;
            assign rvalid[p]               = r_v1;
        end
    end

endmodule
